// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: WIDTH-bit a+b+cin, per-bit full-adder chain, 1-cycle reg.
// Optional signed overflow output ovf when RCA_OVERFLOW_EN is defined.

module rca_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef RCA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    rca_fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Capture the chain result on accepted operands; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[WIDTH];
      end
    end
  end

`ifdef RCA_OVERFLOW_EN
  // Signed overflow: carry into MSB differs from carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[WIDTH-1] ^ c[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: scoreboard bench for WIDTH=4 and WIDTH=16 adders.
// Expected outputs are queued when stimulus is driven, popped one cycle later.

module tb_ripple_carry_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        cin;
  logic [3:0]  sum;
  logic        cout;
  logic        out_valid;

  logic        in_valid16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic [15:0] sum16;
  logic        cout16;
  logic        out_valid16;

`ifdef RCA_OVERFLOW_EN
  logic        ovf;
  logic        ovf16;
`endif

  always #5 clk = ~clk;

  ripple_carry_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
`ifdef RCA_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  ripple_carry_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .sum       (sum16),
    .cout      (cout16),
`ifdef RCA_OVERFLOW_EN
    .ovf       (ovf16),
`endif
    .out_valid (out_valid16)
  );

  typedef struct packed {
    logic [3:0] s;
    logic       c;
    logic       o;
    logic       v;
  } exp_t;

  exp_t q[$];
  exp_t e;

  logic [3:0] ms;
  logic       mc;
  logic       mo;
  logic       mv;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic sovf(input logic [3:0] x, input logic [3:0] y,
                                input logic ci);
    int r;
    r = $signed(x) + $signed(y) + int'(ci);
    return (r > 7) || (r < -8);
  endfunction

  // Drive one cycle of stimulus, queue the expected output, wait to negedge.
  task automatic apply(input logic r, input logic v, input logic [3:0] x,
                       input logic [3:0] y, input logic ci);
    rst = r; in_valid = v; a = x; b = y; cin = ci;
    if (r) begin
      ms = 4'd0; mc = 1'b0; mo = 1'b0; mv = 1'b0;
    end else begin
      mv = v;
      if (v) begin
        {mc, ms} = x + y + ci;
        mo = sovf(x, y, ci);
      end
    end
    q.push_back('{ms, mc, mo, mv});
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 4'hf, 4'hf, 1'b0);
      e = q.pop_front();
      n_cmp++;
      if ({sum, cout, out_valid} !== {4'd0, 1'b0, 1'b0}
          || {sum, cout, out_valid} !== {e.s, e.c, e.v}) begin
        n_bad++;
        $display("FAIL reset[%0d]: got sum=%h cout=%b vld=%b need 0 0 0",
                 i, sum, cout, out_valid);
      end
`ifdef RCA_OVERFLOW_EN
      n_cmp++;
      if (ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ovf[%0d]: got %b need 0", i, ovf);
      end
`endif
    end
  endtask

  task automatic test_directed();
    logic [8:0] v [7];
    logic [4:0] want [7];
    v[0] = {4'b0000, 4'b0000, 1'b0}; want[0] = 5'b0_0000;
    v[1] = {4'b0001, 4'b0001, 1'b0}; want[1] = 5'b0_0010;
    v[2] = {4'b0010, 4'b0011, 1'b0}; want[2] = 5'b0_0101;
    v[3] = {4'b0101, 4'b0110, 1'b0}; want[3] = 5'b0_1011;
    v[4] = {4'b1001, 4'b0111, 1'b1}; want[4] = 5'b1_0001;
    v[5] = {4'b1111, 4'b1111, 1'b0}; want[5] = 5'b1_1110;
    v[6] = {4'b1111, 4'b0001, 1'b1}; want[6] = 5'b1_0001;
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 1'b1, v[i][8:5], v[i][4:1], v[i][0]);
      e = q.pop_front();
      n_cmp++;
      if ({cout, sum, out_valid} !== {want[i], 1'b1}
          || {sum, cout, out_valid} !== {e.s, e.c, e.v}) begin
        n_bad++;
        $display("FAIL directed[%0d]: got cout=%b sum=%b vld=%b need %b vld=1",
                 i, cout, sum, out_valid, want[i]);
      end
`ifdef RCA_OVERFLOW_EN
      n_cmp++;
      if (ovf !== e.o) begin
        n_bad++;
        $display("FAIL directed_ovf[%0d]: got %b need %b", i, ovf, e.o);
      end
`endif
    end
  endtask

  task automatic test_ripple();
    apply(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1);
    e = q.pop_front();
    n_cmp++;
    if ({sum, cout, out_valid} !== {4'b0000, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL ripple: got sum=%b cout=%b vld=%b need 0000 1 1",
               sum, cout, out_valid);
    end
  endtask

  task automatic test_hold();
    apply(1'b0, 1'b1, 4'b0010, 4'b0011, 1'b0);
    e = q.pop_front();
    n_cmp++;
    if ({sum, cout, out_valid} !== {4'b0101, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL hold_load: got sum=%b cout=%b vld=%b need 0101 0 1",
               sum, cout, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 4'(4'hf - i), 4'(4'h9 + i), 1'b1);
      e = q.pop_front();
      n_cmp++;
      if ({sum, cout, out_valid} !== {4'b0101, 1'b0, 1'b0}
          || {sum, cout, out_valid} !== {e.s, e.c, e.v}) begin
        n_bad++;
        $display("FAIL hold[%0d]: got sum=%b cout=%b vld=%b need 0101 0 0",
                 i, sum, cout, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
    e = q.pop_front();
    apply(1'b1, 1'b1, 4'b0101, 4'b0110, 1'b0);
    e = q.pop_front();
    n_cmp++;
    if ({sum, cout, out_valid} !== {4'b0000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: got sum=%b cout=%b vld=%b need 0000 0 0",
               sum, cout, out_valid);
    end
`ifdef RCA_OVERFLOW_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_ovf: got %b need 0", ovf);
    end
`endif
    apply(1'b0, 1'b1, 4'b0011, 4'b0100, 1'b1);
    e = q.pop_front();
    n_cmp++;
    if ({sum, cout, out_valid} !== {4'b1000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL after_reset: got sum=%b cout=%b vld=%b need 1000 0 1",
               sum, cout, out_valid);
    end
  endtask

  task automatic test_exhaustive();
    int bad0;
    bad0 = n_bad;
    for (int k = 0; k < 512; k++) begin
      apply(1'b0, 1'b1, 4'(k >> 5), 4'(k >> 1), k[0]);
      e = q.pop_front();
      n_cmp++;
      if ({sum, cout, out_valid} !== {e.s, e.c, e.v}) begin
        n_bad++;
        if (n_bad - bad0 < 8)
          $display("FAIL exh[%0d]: got sum=%h cout=%b vld=%b need %h %b %b",
                   k, sum, cout, out_valid, e.s, e.c, e.v);
      end
`ifdef RCA_OVERFLOW_EN
      n_cmp++;
      if (ovf !== e.o) begin
        n_bad++;
        if (n_bad - bad0 < 8)
          $display("FAIL exh_ovf[%0d]: got %b need %b", k, ovf, e.o);
      end
`endif
    end
  endtask

  task automatic test_random16();
    logic [16:0] q16[$];
    logic [16:0] w;
    logic [15:0] x;
    logic [15:0] y;
    logic        ci;
    in_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      ci = 1'($urandom);
      if (k == 0) begin x = 16'hffff; y = 16'h0000; ci = 1'b1; end
      if (k == 1) begin x = 16'hffff; y = 16'hffff; ci = 1'b0; end
      in_valid16 = 1'b1; a16 = x; b16 = y; cin16 = ci;
      q16.push_back(17'(x) + 17'(y) + 17'(ci));
      @(negedge clk);
      w = q16.pop_front();
      n_cmp++;
      if ({cout16, sum16, out_valid16} !== {w, 1'b1}) begin
        n_bad++;
        $display("FAIL rand16[%0d]: got cout=%b sum=%h vld=%b need %h vld=1",
                 k, cout16, sum16, out_valid16, w);
      end
    end
    in_valid16 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    test_reset();
    test_directed();
    test_ripple();
    test_hold();
    test_reset_mid();
    test_exhaustive();
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
Parameterised binary adder built as a structural chain of WIDTH full-adder cells. Carry ripples from bit 0 to bit WIDTH-1, and results are captured in an output register with a valid flag. It serves as the basic registered arithmetic primitive for datapath blocks that need a+b+cin with carry-out on a single clock.

Parameters:
WIDTH, 4, operand and sum width in bits (legal range 1 to 64).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands on a, b and cin are valid this cycle.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
cin  input  1  carry into bit 0.
sum  output  WIDTH  registered sum bits.
cout  output  1  registered carry out of bit WIDTH-1.
out_valid  output  1  sum and cout hold a new result this cycle.

Behaviour:
- Datapath:
  - Bit i cell: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = majority(a[i], b[i], c[i]).
  - c[0] = cin. The chain is implemented as instantiated per-bit cells, with no carry-lookahead.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). There is no saturation.
- Latency:
  - Exactly 1 clock.
  - Operands sampled at edge N with in_valid=1 appear on sum/cout at edge N, with out_valid=1 during the following cycle.
- Register update:
  - When in_valid=1, sum and cout load the new result.
  - When in_valid=0, sum and cout hold their previous values.
  - out_valid <= in_valid every cycle, so it is a one-cycle pulse per accepted operand set.
- Handshake:
  - There is no backpressure; a new operand set is accepted every cycle.
  - Back-to-back in_valid pulses produce back-to-back results.
- Reset:
  - When rst=1 at a rising edge: sum=0, cout=0, out_valid=0. Reset takes priority over in_valid.
  - Reset while in_valid=1 discards that operand set; out_valid stays 0 the next cycle.
  - The first operand set after reset deasserts is accepted normally.
- Boundary cases:
  - All-ones plus all-ones with cin=0: sum = all-ones minus 1, cout=1.
  - All-ones plus 0 with cin=1: sum=0, cout=1 (full carry propagation through every cell).
  - 0+0+0: sum=0, cout=0.
- Outputs are driven only from flops, with no combinational path from inputs to outputs.
- No X propagation from the hold path: the registers are always defined after reset.

Optional Feature:
Macro RCA_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (output, 1 bit), the signed two's-complement overflow flag, equal to c[WIDTH-1] ^ c[WIDTH] (carry into MSB XOR carry out).
  - ovf is registered alongside sum/cout with the same enable and hold rules, and resets to 0.
- Undefined:
  - The ovf port and its register do not exist.
  - All other behaviour is identical.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1, a=4'b1111, b=4'b1111 -> sum=0000, cout=0, out_valid=0 throughout; with the macro defined, ovf=0.
2. Directed vectors (WIDTH=4), one per cycle with in_valid=1. Each result appears one cycle later with out_valid=1:
   - 0000+0000+0 -> 0000, cout 0.
   - 0001+0001+0 -> 0010, cout 0.
   - 0010+0011+0 -> 0101, cout 0.
   - 0101+0110+0 -> 1011, cout 0 (ovf=1).
   - 1001+0111+1 -> 0001, cout 1.
   - 1111+1111+0 -> 1110, cout 1 (ovf=0).
   - 1111+0001+1 -> 0001, cout 1.
3. Full carry ripple: a=1111, b=0000, cin=1 -> sum=0000, cout=1 after 1 clock.
4. Hold: apply a=0010, b=0011, cin=0 with in_valid=1, then change a/b for 3 cycles with in_valid=0 -> sum stays 0101, cout stays 0, out_valid=1 for exactly one cycle.
5. Reset mid-stream: in_valid=1 with a=0101, b=0110, cin=0, and rst=1 on the same edge -> sum=0000, cout=0, out_valid=0; the next operand set after rst falls is processed correctly.
6. Exhaustive check at WIDTH=4: all 512 combinations of a, b and cin with in_valid=1 -> every result equals a+b+cin one cycle later. Repeat with random vectors at WIDTH=16.
